mc_latency_responder: RTL and testbench

Synthesizable memory-controller responder that services the requests `phold` issues on its `mc_rq_*` port and returns them on the `mc_rs_*` port. It is a bounded-latency, in-order model with backpressure and a local 64-bit RAM. It replaces the ideal behaviour of `dummy_mc` in benches and FPGA bring-up where realistic latency, stall and flush handling must be exercised. It sits between `phold` and the memory side, with one instance per MC port.

---
 rtl/mc_pkg.sv | 42 ++++
 rtl/mc_rq_fifo.sv | 74 +++++++
 rtl/mc_latency_responder.sv | 166 ++++++++++++++++
 tb/tb_mc_latency_responder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants and the request-queue entry type for mc_latency_responder.
package mc_pkg;

  localparam int unsigned MC_CMD_W     = 3;
  localparam int unsigned MC_VADR_W    = 48;
  localparam int unsigned MC_DATA_W    = 64;
  localparam int unsigned MC_STAMP_W   = 16;
  localparam int unsigned MC_IDX_MAX_W = 16;
  localparam int unsigned MC_TAG_MAX_W = 64;
  localparam int unsigned MC_LAT_W     = 9;

  localparam logic [MC_CMD_W-1:0] MC_CMD_RD8       = 3'd1;
  localparam logic [MC_CMD_W-1:0] MC_CMD_WR8       = 3'd2;
  localparam logic [MC_CMD_W-1:0] MC_RS_RD_DATA    = 3'd2;
  localparam logic [MC_CMD_W-1:0] MC_RS_WR_CMPL    = 3'd3;
  localparam logic [MC_CMD_W-1:0] MC_RS_FLUSH_CMPL = 3'd7;

  typedef enum logic [1:0] {
    ENT_RD    = 2'd0,
    ENT_WR    = 2'd1,
    ENT_FLUSH = 2'd2
  } mc_ent_kind_e;

  // Fields sized for the largest supported RAM index and tag; unused upper bits stay 0.
  typedef struct packed {
    mc_ent_kind_e            kind;
    logic [MC_IDX_MAX_W-1:0] idx;
    logic [MC_TAG_MAX_W-1:0] rtnctl;
    logic [MC_DATA_W-1:0]    data;
    logic [MC_STAMP_W-1:0]   stamp;
    logic [MC_LAT_W-1:0]     lat;
  } mc_ent_t;

  function automatic logic [MC_CMD_W-1:0] rs_cmd_of(input mc_ent_kind_e kind);
    case (kind)
      ENT_RD:  return MC_RS_RD_DATA;
      ENT_WR:  return MC_RS_WR_CMPL;
      default: return MC_RS_FLUSH_CMPL;
    endcase
  endfunction

endpackage

// File: rtl/mc_rq_fifo.sv
// Request queue: two pushes per cycle (request then flush marker), one pop,
// registered almost-full and sticky overflow flags.
module mc_rq_fifo
  import mc_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push0,
  input  mc_ent_t ent0,
  input  logic    push1,
  input  mc_ent_t ent1,
  input  logic    pop,
  output mc_ent_t head_c,
  output logic    not_empty,
  output logic    afull,
  output logic    ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  mc_ent_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr1_c;
  logic [CNT_W-1:0] count_q, count_d, cnt_after0_c;
  logic             acc0_c, acc1_c, pop_ok_c;
  logic             not_empty_q, not_empty_d, afull_q, afull_d, ovf_q, ovf_d;

  // Capacity is judged on the count before this cycle's pop.
  always_comb begin
    acc0_c       = push0 && (count_q != CNT_W'(DEPTH));
    cnt_after0_c = count_q + CNT_W'(acc0_c);
    acc1_c       = push1 && (cnt_after0_c != CNT_W'(DEPTH));
    pop_ok_c     = pop && (count_q != '0);
    wr_ptr1_c    = wr_ptr_q + PTR_W'(acc0_c);
    wr_ptr_d     = wr_ptr1_c + PTR_W'(acc1_c);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop_ok_c);
    count_d      = cnt_after0_c + CNT_W'(acc1_c) - CNT_W'(pop_ok_c);
    not_empty_d  = (count_d != '0);
    afull_d      = (count_d >= CNT_W'(AFULL_LVL));
    ovf_d        = ovf_q | (push0 & ~acc0_c) | (push1 & ~acc1_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      not_empty_q <= 1'b0;
      afull_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      not_empty_q <= not_empty_d;
      afull_q     <= afull_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc0_c) mem[wr_ptr_q] <= ent0;
    if (acc1_c) mem[wr_ptr1_c] <= ent1;
  end

  assign head_c    = mem[rd_ptr_q];
  assign not_empty = not_empty_q;
  assign afull     = afull_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/mc_latency_responder.sv
// Bounded-latency in-order MC responder with local 64-bit RAM accessed at pop time.
// Optional per-entry latency jitter: define MC_RESP_JITTER_EN.
module mc_latency_responder
  import mc_pkg::*;
#(
  parameter int unsigned MC_RTNCTL_WIDTH = 32,
  parameter int unsigned RAM_DEPTH       = 2048,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned STALL_MARGIN    = 4,
  parameter int unsigned LATENCY         = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mc_rq_vld,
  input  logic [2:0]                 mc_rq_cmd,
  input  logic [3:0]                 mc_rq_scmd,
  input  logic [47:0]                mc_rq_vadr,
  input  logic [1:0]                 mc_rq_size,
  input  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  input  logic [63:0]                mc_rq_data,
  input  logic                       mc_rq_flush,
  output logic                       mc_rq_stall,
  output logic                       mc_rs_vld,
  output logic [2:0]                 mc_rs_cmd,
  output logic [3:0]                 mc_rs_scmd,
  output logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  output logic [63:0]                mc_rs_data,
  input  logic                       mc_rs_stall,
  output logic                       ovf_err,
  output logic [15:0]                bad_cmd
);

  localparam int unsigned IDX_W = $clog2(RAM_DEPTH);

  logic [MC_STAMP_W-1:0]      cyc_q, cyc_d, age_c;
  logic [15:0]                bad_cmd_q, bad_cmd_d;
  logic                       rs_vld_q, rs_vld_d;
  logic [2:0]                 rs_cmd_q, rs_cmd_d;
  logic [MC_RTNCTL_WIDTH-1:0] rs_rtnctl_q, rs_rtnctl_d;
  logic [63:0]                rs_data_q, rs_data_d;
  logic                       cmd_ok_c, push0_c, push1_c, pop_c, ram_we_c;
  logic                       not_empty, unused_c;
  logic [IDX_W-1:0]           ram_idx_c;
  logic [63:0]                ram_rd_c;
  logic [MC_LAT_W-1:0]        lat_c;
  mc_ent_t                    ent0_c, ent1_c, head_c;
  logic [63:0]                ram_mem [RAM_DEPTH];

`ifdef MC_RESP_JITTER_EN
  logic [15:0]         lfsr_q, lfsr_d;
  logic [MC_LAT_W-1:0] last_lat_q, last_lat_d, req_lat_c;

  // Never shorter than the predecessor's latency, so order is preserved.
  always_comb begin
    lfsr_d     = lfsr_q;
    req_lat_c  = MC_LAT_W'(LATENCY - 1) + MC_LAT_W'(lfsr_q[2:0]);
    lat_c      = (req_lat_c > last_lat_q) ? req_lat_c : last_lat_q;
    last_lat_d = last_lat_q;
    if (push0_c || push1_c) begin
      lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      last_lat_d = lat_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q     <= 16'hACE1;
      last_lat_q <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      last_lat_q <= last_lat_d;
    end
  end
`else
  assign lat_c = MC_LAT_W'(LATENCY - 1);
`endif

  always_comb begin
    cyc_d    = cyc_q + MC_STAMP_W'(1);
    cmd_ok_c = (mc_rq_cmd == MC_CMD_RD8) || (mc_rq_cmd == MC_CMD_WR8);
    push0_c  = mc_rq_vld && cmd_ok_c;
    push1_c  = mc_rq_flush;

    bad_cmd_d = bad_cmd_q;
    if (mc_rq_vld && !cmd_ok_c && (bad_cmd_q != 16'hFFFF)) bad_cmd_d = bad_cmd_q + 16'd1;

    ent0_c        = '0;
    ent0_c.kind   = (mc_rq_cmd == MC_CMD_WR8) ? ENT_WR : ENT_RD;
    ent0_c.idx    = MC_IDX_MAX_W'(mc_rq_vadr[3 +: IDX_W]);
    ent0_c.rtnctl = MC_TAG_MAX_W'(mc_rq_rtnctl);
    ent0_c.data   = mc_rq_data;
    ent0_c.stamp  = cyc_q;
    ent0_c.lat    = lat_c;

    ent1_c       = '0;
    ent1_c.kind  = ENT_FLUSH;
    ent1_c.stamp = cyc_q;
    ent1_c.lat   = lat_c;

    // Modulo age keeps eligibility correct across the counter wrap.
    age_c     = cyc_q - head_c.stamp;
    pop_c     = not_empty && !mc_rs_stall && (age_c >= MC_STAMP_W'(head_c.lat));
    ram_idx_c = IDX_W'(head_c.idx);
    ram_we_c  = rst_n && pop_c && (head_c.kind == ENT_WR);

    rs_vld_d    = pop_c;
    rs_cmd_d    = rs_cmd_q;
    rs_rtnctl_d = rs_rtnctl_q;
    rs_data_d   = rs_data_q;
    if (pop_c) begin
      rs_cmd_d    = rs_cmd_of(head_c.kind);
      rs_rtnctl_d = (head_c.kind == ENT_FLUSH) ? '0 : MC_RTNCTL_WIDTH'(head_c.rtnctl);
      rs_data_d   = (head_c.kind == ENT_RD) ? ram_rd_c : 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q       <= '0;
      bad_cmd_q   <= '0;
      rs_vld_q    <= 1'b0;
      rs_cmd_q    <= '0;
      rs_rtnctl_q <= '0;
      rs_data_q   <= '0;
    end else begin
      cyc_q       <= cyc_d;
      bad_cmd_q   <= bad_cmd_d;
      rs_vld_q    <= rs_vld_d;
      rs_cmd_q    <= rs_cmd_d;
      rs_rtnctl_q <= rs_rtnctl_d;
      rs_data_q   <= rs_data_d;
    end
  end

  // RAM has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (ram_we_c) ram_mem[ram_idx_c] <= head_c.data;
  end
  assign ram_rd_c = ram_mem[ram_idx_c];

  mc_rq_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .AFULL_LVL (FIFO_DEPTH - STALL_MARGIN)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push0     (push0_c),
    .ent0      (ent0_c),
    .push1     (push1_c),
    .ent1      (ent1_c),
    .pop       (pop_c),
    .head_c    (head_c),
    .not_empty (not_empty),
    .afull     (mc_rq_stall),
    .ovf       (ovf_err)
  );

  assign unused_c     = ^{mc_rq_scmd, mc_rq_size, mc_rq_vadr, head_c};
  assign mc_rs_vld    = rs_vld_q;
  assign mc_rs_cmd    = rs_cmd_q;
  assign mc_rs_scmd   = 4'd0;
  assign mc_rs_rtnctl = rs_rtnctl_q;
  assign mc_rs_data   = rs_data_q;
  assign bad_cmd      = bad_cmd_q;

endmodule

// File: tb/tb_mc_latency_responder.sv
// Self-checking bench for mc_latency_responder: lockstep queue model, vector table,
// directed corner sequences and randomized traffic.
module tb_mc_latency_responder;
  import mc_pkg::*;

  localparam int LAT = 8;
  localparam int FD  = 16;
  localparam int SM  = 4;

  logic        clk = 1'b0;
  logic        rst_n, rq_vld, rq_flush, rs_stall;
  logic [2:0]  rq_cmd;
  logic [3:0]  rq_scmd;
  logic [47:0] rq_vadr;
  logic [1:0]  rq_size;
  logic [31:0] rq_tag;
  logic [63:0] rq_data;
  logic        mc_rq_stall, mc_rs_vld, ovf_err;
  logic [2:0]  mc_rs_cmd;
  logic [3:0]  mc_rs_scmd;
  logic [31:0] mc_rs_rtnctl;
  logic [63:0] mc_rs_data;
  logic [15:0] bad_cmd;

  mc_latency_responder #(
    .MC_RTNCTL_WIDTH(32), .RAM_DEPTH(2048), .FIFO_DEPTH(FD),
    .STALL_MARGIN(SM), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mc_rq_vld(rq_vld), .mc_rq_cmd(rq_cmd),
    .mc_rq_scmd(rq_scmd), .mc_rq_vadr(rq_vadr), .mc_rq_size(rq_size),
    .mc_rq_rtnctl(rq_tag), .mc_rq_data(rq_data), .mc_rq_flush(rq_flush),
    .mc_rq_stall(mc_rq_stall), .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd),
    .mc_rs_scmd(mc_rs_scmd), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data),
    .mc_rs_stall(rs_stall), .ovf_err(ovf_err), .bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rs_cmd;
    int unsigned idx;
    logic [31:0] tag;
    logic [63:0] data;
    int          stamp;
  } m_ent_t;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] tag;
    logic [63:0] data;
    int          edge_n;
  } rsp_t;

  typedef struct {
    logic [2:0]  cmd;
    logic [47:0] vadr;
    logic [31:0] tag;
    logic [63:0] wdata;
    bit          exp_rsp;
    logic [2:0]  exp_cmd;
    logic [63:0] exp_data;
  } vec_t;

  m_ent_t      mq[$];
  rsp_t        cap_q[$];
  logic [63:0] mram[int unsigned];
  int          tests = 0, fails = 0, edge_n = 0, now = 0;
  bit          chk_en = 1'b1, just_rst = 1'b0;
  logic        e_vld, e_stall, e_ovf;
  logic [2:0]  e_cmd;
  logic [31:0] e_tag;
  logic [63:0] e_data;
  logic [15:0] e_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int unsigned idx_of(input logic [47:0] a);
    return int'((a >> 3) & 48'h7FF);
  endfunction

  // Reference: a plain in-order queue of timestamped entries, one pop per cycle.
  task automatic model_edge();
    int occ;
    m_ent_t h, n;
    if (!rst_n) begin
      mq.delete(); now = 0; just_rst = 1'b1;
      e_vld = 0; e_cmd = 0; e_tag = 0; e_data = 0; e_stall = 0; e_ovf = 0; e_bad = 0;
      return;
    end
    just_rst = 1'b0;
    occ = mq.size();
    e_vld = 1'b0;
    if (occ > 0 && (now - mq[0].stamp) >= LAT - 1 && !rs_stall) begin
      h = mq.pop_front();
      e_vld = 1'b1; e_cmd = h.rs_cmd; e_tag = h.tag; e_data = 64'd0;
      if (h.rs_cmd == MC_RS_RD_DATA) e_data = mram[h.idx];
      if (h.rs_cmd == MC_RS_WR_CMPL) mram[h.idx] = h.data;
    end
    if (rq_vld) begin
      if (rq_cmd == 3'd1 || rq_cmd == 3'd2) begin
        if (occ < FD) begin
          n.rs_cmd = (rq_cmd == 3'd1) ? MC_RS_RD_DATA : MC_RS_WR_CMPL;
          n.idx = idx_of(rq_vadr); n.tag = rq_tag; n.data = rq_data; n.stamp = now;
          mq.push_back(n); occ++;
        end else e_ovf = 1'b1;
      end else if (e_bad != 16'hFFFF) e_bad = e_bad + 16'd1;
    end
    if (rq_flush) begin
      if (occ < FD) begin
        n.rs_cmd = MC_RS_FLUSH_CMPL; n.idx = 0; n.tag = 0; n.data = 0; n.stamp = now;
        mq.push_back(n);
      end else e_ovf = 1'b1;
    end
    now++;
    e_stall = (mq.size() >= FD - SM);
  endtask

  task automatic check_outputs();
    check("rs_vld", 64'(mc_rs_vld), 64'(e_vld));
    if (e_vld || just_rst) begin
      check("rs_cmd", 64'(mc_rs_cmd), 64'(e_cmd));
      check("rs_rtnctl", 64'(mc_rs_rtnctl), 64'(e_tag));
      check("rs_data", mc_rs_data, e_data);
      check("rs_scmd", 64'(mc_rs_scmd), 64'd0);
    end
    check("rq_stall", 64'(mc_rq_stall), 64'(e_stall));
    check("ovf_err", 64'(ovf_err), 64'(e_ovf));
    check("bad_cmd", 64'(bad_cmd), 64'(e_bad));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    edge_n++;
    #1;
    if (chk_en) check_outputs();
    if (mc_rs_vld === 1'b1) cap_q.push_back('{mc_rs_cmd, mc_rs_rtnctl, mc_rs_data, edge_n});
  endtask

  task automatic send(input logic [2:0] c, input logic [47:0] a, input logic [31:0] t,
                      input logic [63:0] d, input logic fl);
    rq_vld = 1'b1; rq_cmd = c; rq_vadr = a; rq_tag = t; rq_data = d; rq_flush = fl;
    rq_scmd = 4'($urandom); rq_size = 2'($urandom);
    tick();
    rq_vld = 1'b0; rq_flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || e_vld) && n < 400) begin tick(); n++; end
    tick();
    tests++;
    if (n >= 400) begin fails++; $display("FAIL drain: queue not empty after %0d cycles", n); end
  endtask

  task automatic check_consec(input string name, input int n);
    check({name, "_count"}, 64'(cap_q.size()), 64'(n));
    for (int i = 1; i < n && i < cap_q.size(); i++)
      check({name, "_gap"}, 64'(cap_q[i].edge_n - cap_q[i-1].edge_n), 64'd1);
  endtask

  vec_t vec [9];

  initial begin
    int s;
    bit seen_stall;
    logic [2:0] c;
    rst_n = 1'b0; rq_vld = 0; rq_flush = 0; rs_stall = 0; rq_cmd = 0; rq_scmd = 0;
    rq_vadr = 0; rq_size = 0; rq_tag = 0; rq_data = 0;
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      send(MC_CMD_WR8, 48'h100 + 48'(8 * i), 32'(i), {32'h5A5A0000, 32'(i)}, 1'b0);
    send(MC_CMD_WR8, 48'h200, 32'd1, 64'h2222_2222_0000_0200, 1'b0);
    send(MC_CMD_WR8, 48'h300, 32'd2, 64'h3333_3333_0000_0300, 1'b0);
    drain();

    // Vector table: back-to-back requests, hand-computed responses.
    vec[0] = '{MC_CMD_WR8, 48'h40,   32'd5,  64'hDEADBEEF_00000001, 1, MC_RS_WR_CMPL, 64'h0};
    vec[1] = '{MC_CMD_RD8, 48'h40,   32'd6,  64'h0, 1, MC_RS_RD_DATA, 64'hDEADBEEF_00000001};
    vec[2] = '{MC_CMD_WR8, 48'h48,   32'd7,  64'h1234, 1, MC_RS_WR_CMPL, 64'h0};
    vec[3] = '{MC_CMD_RD8, 48'h48,   32'd8,  64'h0, 1, MC_RS_RD_DATA, 64'h1234};
    vec[4] = '{MC_CMD_RD8, 48'h40,   32'd9,  64'h0, 1, MC_RS_RD_DATA, 64'hDEADBEEF_00000001};
    vec[5] = '{MC_CMD_WR8, 48'h4045, 32'd10, 64'hCAFE, 1, MC_RS_WR_CMPL, 64'h0};
    vec[6] = '{MC_CMD_RD8, 48'h40,   32'd11, 64'h0, 1, MC_RS_RD_DATA, 64'hCAFE};
    vec[7] = '{3'd0,       48'h40,   32'd12, 64'h0, 0, 3'd0, 64'h0};
    vec[8] = '{MC_CMD_RD8, 48'h48,   32'd13, 64'h0, 1, MC_RS_RD_DATA, 64'h1234};
    cap_q.delete();
    s = edge_n;
    foreach (vec[i]) send(vec[i].cmd, vec[i].vadr, vec[i].tag, vec[i].wdata, 1'b0);
    drain();
    check("vec_count", 64'(cap_q.size()), 64'd8);
    begin
      int j = 0;
      for (int i = 0; i < 9; i++) begin
        if (vec[i].exp_rsp && j < cap_q.size()) begin
          check("vec_cmd", 64'(cap_q[j].cmd), 64'(vec[i].exp_cmd));
          check("vec_tag", 64'(cap_q[j].tag), 64'(vec[i].tag));
          check("vec_data", cap_q[j].data, vec[i].exp_data);
          check("vec_latency", 64'(cap_q[j].edge_n - (s + 1 + i)), 64'(LAT - 1));
          j++;
        end
      end
    end
    check("vec_bad_cmd", 64'(bad_cmd), 64'd1);

    // 20 back-to-back reads
    cap_q.delete();
    for (int i = 0; i < 20; i++)
      send(MC_CMD_RD8, (i % 2 == 0) ? 48'h40 : 48'h48, 32'(20 + i), 64'h0, 1'b0);
    drain();
    check_consec("b2b", 20);
    for (int i = 0; i < cap_q.size(); i++) begin
      check("b2b_tag", 64'(cap_q[i].tag), 64'(20 + i));
      check("b2b_data", cap_q[i].data, (i % 2 == 0) ? 64'hCAFE : 64'h1234);
    end
    check("b2b_ovf", 64'(ovf_err), 64'd0);

    // Consumer stall across the eligibility point
    cap_q.delete();
    for (int i = 0; i < 4; i++) send(MC_CMD_RD8, 48'h48, 32'(100 + i), 64'h0, 1'b0);
    s = edge_n;
    rs_stall = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("cstall_quiet", 64'(cap_q.size()), 64'd0);
    rs_stall = 1'b0;
    drain();
    check_consec("cstall", 4);
    for (int i = 0; i < cap_q.size(); i++) check("cstall_tag", 64'(cap_q[i].tag), 64'(100 + i));
    if (cap_q.size() > 0) check("cstall_first", 64'(cap_q[0].edge_n), 64'(s + 11));

    // Flush after writes, then flush together with a read
    cap_q.delete();
    for (int i = 0; i < 3; i++) send(MC_CMD_WR8, 48'h500 + 48'(8 * i), 32'(40 + i), 64'(i), 1'b0);
    rq_flush = 1'b1; tick(); rq_flush = 1'b0;
    send(MC_CMD_RD8, 48'h40, 32'd55, 64'h0, 1'b1);
    drain();
    check("flush_count", 64'(cap_q.size()), 64'd6);
    if (cap_q.size() == 6) begin
      check("flush_cmd3", 64'(cap_q[2].cmd), 64'(MC_RS_WR_CMPL));
      check("flush_cmd4", 64'(cap_q[3].cmd), 64'(MC_RS_FLUSH_CMPL));
      check("flush_tag4", 64'(cap_q[3].tag), 64'd0);
      check("flush_data4", cap_q[3].data, 64'd0);
      check("dual_rd_cmd", 64'(cap_q[4].cmd), 64'(MC_RS_RD_DATA));
      check("dual_rd_tag", 64'(cap_q[4].tag), 64'd55);
      check("dual_fl_cmd", 64'(cap_q[5].cmd), 64'(MC_RS_FLUSH_CMPL));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rs_stall = ($urandom % 5 == 0);
      rq_vld   = mc_rq_stall ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      c = ($urandom % 10 < 5) ? MC_CMD_RD8 : MC_CMD_WR8;
      if ($urandom % 12 == 0) c = ($urandom % 2 == 0) ? 3'd0 : 3'($urandom_range(3, 7));
      rq_cmd   = c;
      rq_vadr  = 48'h100 + 48'(8 * ($urandom % 8)) + (48'($urandom % 4) << 14);
      rq_tag   = $urandom;
      rq_data  = {$urandom, $urandom};
      rq_flush = ($urandom % 16 == 0);
      rq_scmd  = 4'($urandom);
      rq_size  = 2'($urandom);
      tick();
    end
    rq_vld = 0; rq_flush = 0; rs_stall = 0;
    drain();

    // Overflow while the consumer is stalled
    cap_q.delete();
    rs_stall = 1'b1;
    seen_stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(MC_CMD_RD8, 48'h48, 32'(200 + i), 64'h0, 1'b0);
      if (mc_rq_stall) seen_stall = 1'b1;
    end
    check("ovf_set", 64'(ovf_err), 64'd1);
    check("ovf_stall_seen", 64'(seen_stall), 64'd1);
    rs_stall = 1'b0;
    drain();
    check_consec("ovf", 16);
    for (int i = 0; i < cap_q.size(); i++) check("ovf_tag", 64'(cap_q[i].tag), 64'(200 + i));

    // Reset with five entries queued: queued write is discarded, RAM retained
    cap_q.delete();
    send(MC_CMD_WR8, 48'h300, 32'd70, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
    for (int i = 0; i < 4; i++) send(MC_CMD_RD8, 48'h200, 32'(71 + i), 64'h0, 1'b0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("rst_vld", 64'(mc_rs_vld), 64'd0);
    check("rst_ovf", 64'(ovf_err), 64'd0);
    check("rst_bad", 64'(bad_cmd), 64'd0);
    check("rst_data", mc_rs_data, 64'd0);
    for (int i = 0; i < 20; i++) tick();
    check("rst_quiet", 64'(cap_q.size()), 64'd0);
    send(MC_CMD_RD8, 48'h300, 32'd80, 64'h0, 1'b0);
    send(MC_CMD_RD8, 48'h200, 32'd81, 64'h0, 1'b0);
    drain();
    check("rst_rd_count", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() == 2) begin
      check("rst_rd300", cap_q[0].data, 64'h3333_3333_0000_0300);
      check("rst_rd200", cap_q[1].data, 64'h2222_2222_0000_0200);
    end

    // Requests straddling the 16-bit cycle counter wrap
    chk_en = 1'b0;
    while ((now % 65536) != 65530) tick();
    chk_en = 1'b1;
    cap_q.delete();
    s = edge_n;
    for (int i = 0; i < 12; i++) send(MC_CMD_RD8, 48'h200, 32'(300 + i), 64'h0, 1'b0);
    drain();
    check("wrap_count", 64'(cap_q.size()), 64'd12);
    for (int i = 0; i < cap_q.size(); i++) begin
      check("wrap_tag", 64'(cap_q[i].tag), 64'(300 + i));
      check("wrap_latency", 64'(cap_q[i].edge_n - (s + 1 + i)), 64'(LAT - 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
